// File: rtl/bcd_seek_pkg.sv
// Shared types and helpers for the BCD seek controller and its decade digits.
package bcd_seek_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade up/down BCD digit with synchronous clear and carry/borrow detect.
module bcd_digit
  import bcd_seek_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       up_i,
  output logic [3:0] q_o,
  output logic [3:0] d_o,
  output logic       cy_o,
  output logic       bw_o
);

  logic [3:0] q_q;

  // d_o exposes the value this digit takes at the next edge, so the parent
  // can detect arrival at the target on the stepping edge itself.
  always_comb begin
    d_o = q_q;
    if (en_i) begin
      if (up_i) d_o = (q_q >= BCD_MAX) ? 4'd0 : q_q + 4'd1;
      else      d_o = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   q_q <= 4'd0;
    else if (clr_i) q_q <= 4'd0;
    else            q_q <= d_o;
  end

  assign q_o  = q_q;
  assign cy_o = up_i && (q_q == BCD_MAX);
  assign bw_o = !up_i && (q_q == 4'd0);

endmodule

// File: rtl/bcd_seek_ctrl.sv
// Seeks a chain of BCD decade digits one count at a time toward a commanded
// target, and mirrors each step on en_o/up_o for slaved external counters.
//
// state  | meaning
// S_IDLE | ready for a command
// S_SEEK | stepping Q toward the latched target
// S_DONE | one-cycle completion pulse
module bcd_seek_ctrl
  import bcd_seek_pkg::*;
#(
  parameter int NDIG     = 2,
  parameter int TICK_DIV = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [4*NDIG-1:0] cmd_tgt_i,
  input  logic            cmd_clr_i,
  input  logic            hold_i,
  output logic            en_o,
  output logic            up_o,
  output logic [4*NDIG-1:0] q_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int W  = 4 * NDIG;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [W-1:0]    tgt_q, tgt_d;
  logic            up_q, up_d;
  logic            err_q, err_d;
  logic [W-1:0]    q_cur, q_nxt;
  logic [NDIG-1:0] dig_en, cy, bw, pass;
  logic            tgt_ok, clr_acc, at_limit;

  // Digit i steps only when every lower digit rolls over in the current direction.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign dig_en[i] = en_o;
    end else begin : g_upper
      assign dig_en[i] = dig_en[i-1] & pass[i-1];
    end
    assign pass[i] = cy[i] | bw[i];

    bcd_digit u_dig (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (clr_acc),
      .en_i    (dig_en[i]),
      .up_i    (up_q),
      .q_o     (q_cur[4*i +: 4]),
      .d_o     (q_nxt[4*i +: 4]),
      .cy_o    (cy[i]),
      .bw_o    (bw[i])
    );
  end

  // All digits rolling over means 99..9 going up or 00..0 going down: never wrap.
  assign at_limit = &pass;

  always_comb begin
    tgt_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!bcd_valid(cmd_tgt_i[4*i +: 4])) tgt_ok = 1'b0;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_SEEK);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign up_o        = up_q;
  assign q_o         = q_cur;
  assign en_o        = busy_o && (tick_q == TICK_LAST) && !hold_i && !at_limit;
  assign clr_acc     = cmd_ready_o && cmd_valid_i && cmd_clr_i;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    tgt_d   = tgt_q;
    up_d    = up_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          tick_d = '0;
          if (cmd_clr_i) begin
            state_d = S_DONE;
          end else if (!tgt_ok) begin
            err_d = 1'b1;
          end else if (cmd_tgt_i == q_cur) begin
            state_d = S_DONE;
          end else begin
            tgt_d   = cmd_tgt_i;
            up_d    = (cmd_tgt_i > q_cur);
            state_d = S_SEEK;
          end
        end
      end
      S_SEEK: begin
        if (en_o) begin
          tick_d = '0;
          if (q_nxt == tgt_q) state_d = S_DONE;
        end else if (!hold_i) begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      tgt_q   <= '0;
      up_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      tgt_q   <= tgt_d;
      up_q    <= up_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_seek_ctrl.sv
// Directed bench for bcd_seek_ctrl (NDIG=2), with a TICK_DIV=3 instance for step pacing.
module tb_bcd_seek_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_clr = 1'b0, hold = 1'b0;
  logic [7:0] cmd_tgt = 8'h00;
  logic       ready, en, up, busy, done, err;
  logic [7:0] q;
  logic       v3 = 1'b0, h3 = 1'b0;
  logic       ready3, en3, up3, busy3, done3, err3;
  logic [7:0] q3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_seek_ctrl #(.NDIG(2), .TICK_DIV(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(ready),
    .cmd_tgt_i(cmd_tgt), .cmd_clr_i(cmd_clr), .hold_i(hold), .en_o(en), .up_o(up),
    .q_o(q), .busy_o(busy), .done_o(done), .err_o(err)
  );

  bcd_seek_ctrl #(.NDIG(2), .TICK_DIV(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(v3), .cmd_ready_o(ready3),
    .cmd_tgt_i(cmd_tgt), .cmd_clr_i(cmd_clr), .hold_i(h3), .en_o(en3), .up_o(up3),
    .q_o(q3), .busy_o(busy3), .done_o(done3), .err_o(err3)
  );

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic send(input logic [7:0] t, input logic c);
    @(negedge clk);
    cmd_tgt = t; cmd_clr = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_clr = 1'b0;
  endtask

  task automatic run_seek(input string name, input logic [7:0] tgt, input logic exp_up,
                          input int exp_n, input int exp_done, input logic [7:0] hold_q,
                          input int hold_len, output logic x09, output logic x19);
    int en_cnt = 0, done_at = 0, held = 0;
    logic bad_step = 0, bad_range = 0, bad_up = 0, bad_hold = 0, bad_busy = 0;
    logic [7:0] prev, want;
    x09 = 0; x19 = 0;
    prev = q;
    send(tgt, 1'b0);
    for (int s = 1; s <= 400 && done_at == 0; s++) begin
      @(negedge clk);
      if (hold_len > 0 && q == hold_q && held < hold_len) begin hold = 1'b1; held++; end
      else hold = 1'b0;
      #1;
      if (en) en_cnt++;
      if (!done && (busy !== 1'b1 || up !== exp_up)) begin bad_busy |= (busy !== 1'b1); bad_up |= (up !== exp_up); end
      if (hold && (en !== 1'b0 || q !== hold_q)) bad_hold = 1;
      if (q !== prev) begin
        want = int2bcd(bcd2int(prev) + (exp_up ? 1 : -1));
        if (q !== want) bad_step = 1;
        if ({prev, q} == 16'h0910 || {prev, q} == 16'h1009) x09 = 1;
        if ({prev, q} == 16'h1920 || {prev, q} == 16'h2019) x19 = 1;
      end
      if (exp_up ? (q > tgt) : (q < tgt)) bad_range = 1;
      prev = q;
      if (done) done_at = s;
    end
    hold = 1'b0;
    n_cmp++; if (done_at !== exp_done) begin n_fail++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_at, exp_done); end
    n_cmp++; if (q !== tgt) begin n_fail++; $display("FAIL %s_q_final: got %h want %h", name, q, tgt); end
    n_cmp++; if (en_cnt !== exp_n) begin n_fail++; $display("FAIL %s_en_count: got %0d want %0d", name, en_cnt, exp_n); end
    n_cmp++; if ({bad_step, bad_range, bad_up, bad_hold, bad_busy} !== 5'b0) begin
      n_fail++; $display("FAIL %s_trace: step/range/up/hold/busy flags got %b want 00000", name, {bad_step, bad_range, bad_up, bad_hold, bad_busy});
    end
    @(negedge clk); #1;
    n_cmp++; if ({done, ready} !== 2'b01) begin n_fail++; $display("FAIL %s_after_done: done,ready got %b want 01", name, {done, ready}); end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", q); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (up !== 1'b1) begin n_fail++; $display("FAIL reset_up: got %b want 1", up); end
    n_cmp++; if ({en, busy, done, err} !== 4'b0) begin n_fail++; $display("FAIL reset_en_busy_done_err: got %b want 0000", {en, busy, done, err}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({ready, up, en, busy, done, err, q} !== {6'b110000, 8'h00}) begin
      n_fail++; $display("FAIL reset_release: got %b_%h want 110000_00", {ready, up, en, busy, done, err}, q);
    end
  endtask

  task automatic test_seek_up();
    logic x09, x19;
    run_seek("up25", 8'h25, 1'b1, 25, 26, 8'h00, 0, x09, x19);
    n_cmp++; if ({x09, x19} !== 2'b11) begin n_fail++; $display("FAIL up25_carries: got %b want 11", {x09, x19}); end
  endtask

  task automatic test_seek_down();
    logic x09, x19;
    run_seek("dn07", 8'h07, 1'b0, 18, 19, 8'h00, 0, x09, x19);
    n_cmp++; if ({x09, x19} !== 2'b11) begin n_fail++; $display("FAIL dn07_borrows: got %b want 11", {x09, x19}); end
  endtask

  task automatic test_err_equal();
    send(8'h3A, 1'b0);
    @(negedge clk); #1;
    n_cmp++; if ({err, busy, ready, q} !== {3'b101, 8'h07}) begin n_fail++; $display("FAIL err_pulse: err,busy,ready,q got %b_%h want 101_07", {err, busy, ready}, q); end
    n_cmp++; if (up !== 1'b0) begin n_fail++; $display("FAIL up_holds: got %b want 0", up); end
    @(negedge clk); #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", err); end
    send(8'h07, 1'b0);
    @(negedge clk); #1;
    n_cmp++; if ({done, en, busy, q} !== {3'b100, 8'h07}) begin n_fail++; $display("FAIL equal_done: done,en,busy,q got %b_%h want 100_07", {done, en, busy}, q); end
    @(negedge clk); #1;
    n_cmp++; if ({done, ready, en} !== 3'b010) begin n_fail++; $display("FAIL equal_after: done,ready,en got %b want 010", {done, ready, en}); end
  endtask

  task automatic test_clr_hold();
    logic x09, x19;
    send(8'h07, 1'b1);
    @(negedge clk); #1;
    n_cmp++; if ({done, q} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL clr07: done,q got %b_%h want 1_00", done, q); end
    run_seek("hold12", 8'h12, 1'b1, 12, 16, 8'h05, 3, x09, x19);
  endtask

  task automatic test_tick_div();
    int done_at = 0, bad_en = 0;
    @(negedge clk);
    v3 = 1'b1; cmd_tgt = 8'h12;
    @(posedge clk); #1; v3 = 1'b0;
    for (int s = 1; s <= 200 && done_at == 0; s++) begin
      @(negedge clk); #1;
      if (done3) done_at = s;
      else if (en3 !== ((s % 3) == 0)) bad_en++;
    end
    n_cmp++; if (done_at !== 37) begin n_fail++; $display("FAIL div3_done_cycle: got %0d want 37", done_at); end
    n_cmp++; if (bad_en !== 0) begin n_fail++; $display("FAIL div3_en_pattern: bad cycles got %0d want 0", bad_en); end
    n_cmp++; if (q3 !== 8'h12) begin n_fail++; $display("FAIL div3_q: got %h want 12", q3); end
  endtask

  task automatic test_reset_midseek();
    int found = 0, dn = 0;
    send(8'h25, 1'b0);
    for (int s = 0; s < 50 && found == 0; s++) begin
      @(negedge clk);
      if (q == 8'h13) found = 1;
    end
    n_cmp++; if (found !== 1) begin n_fail++; $display("FAIL midseek_reach13: got %0d want 1", found); end
    rst_n = 1'b0; #1;
    n_cmp++; if ({q, ready, busy, done, up} !== {8'h00, 4'b1001}) begin
      n_fail++; $display("FAIL midseek_async: q,ready,busy,done,up got %h_%b want 00_1001", q, {ready, busy, done, up});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      if (done || busy) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_fail++; $display("FAIL midseek_no_done: done/busy cycles got %0d want 0", dn); end
  endtask

  task automatic test_clr99();
    logic x09, x19;
    run_seek("up99", 8'h99, 1'b1, 99, 100, 8'h00, 0, x09, x19);
    send(8'hFF, 1'b1);
    @(negedge clk); #1;
    n_cmp++; if ({q, done, err} !== {8'h00, 2'b10}) begin n_fail++; $display("FAIL clr99: q,done,err got %h_%b want 00_10", q, {done, err}); end
  endtask

  initial begin
    test_reset();
    test_seek_up();
    test_seek_down();
    test_err_equal();
    test_clr_hold();
    test_tick_div();
    test_reset_midseek();
    test_clr99();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
